// File: rtl/nx_ipchecksum_sched.sv
`default_nettype none
// ============================================================================
// Module   : nx_ipchecksum_sched
// Purpose  : Round-robin scheduler that shares a single IPv4 header checksum
//            unit among NUM_REQ requesters. One operation is in flight at a
//            time: grant -> capture 10-word header -> present the 9
//            non-checksum words to the unit -> wait CS_LATENCY -> latch the
//            result -> hold it until the consumer accepts it.
// Ports    :
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_hdr     per-requester request and 160-bit header
//   req_ready             one-hot grant/accept pulse (IDLE only)
//   cs_word/cs_result     interface to the shared checksum unit
//   out_valid/out_ready   result handshake
//   out_id/out_csum/out_match  result owner, checksum, compare vs word 5
// Options  : `define NX_IPCSUM_SCHED_STATS_EN adds stat_clr, stat_done_cnt and
//            stat_mismatch_cnt (saturating handshake/mismatch counters).
// Revision : 1.0 - initial release
// ============================================================================
module nx_ipchecksum_sched #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int CS_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*160-1:0] req_hdr,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [143:0]           cs_word,
    input  logic [15:0]            cs_result,
`ifdef NX_IPCSUM_SCHED_STATS_EN
    input  logic                   stat_clr,
    output logic [31:0]            stat_done_cnt,
    output logic [31:0]            stat_mismatch_cnt,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [15:0]            out_csum,
    output logic                   out_match
);

    localparam logic [1:0]      S_IDLE    = 2'd0;
    localparam logic [1:0]      S_CALC    = 2'd1;
    localparam logic [1:0]      S_DONE    = 2'd2;
    localparam logic [2:0]      c_LAT     = 3'(CS_LATENCY);
    localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(NUM_REQ - 1);

    logic [1:0]      r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [159:0]    r_hdr;
    logic [2:0]      r_lat_cnt;
    logic            r_out_valid;
    logic [ID_W-1:0] r_out_id;
    logic [15:0]     r_out_csum;
    logic            r_out_match;

    logic            w_any;
    logic [ID_W-1:0] w_gnt_id;
    logic [159:0]    w_sel_hdr;
    logic            w_hs;

    // Round-robin search starting just after the last winner. Scanning from
    // the farthest candidate to the nearest lets the nearest set bit win.
    always_comb begin
        w_any    = 1'b0;
        w_gnt_id = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_any    = 1'b1;
                w_gnt_id = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_sel_hdr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_sel_hdr    = req_hdr[160*i +: 160];
                req_ready[i] = (r_state == S_IDLE) && w_any;
            end
        end
    end

    // Header word 5 (bits [79:64]) is the received checksum and is not summed.
    assign cs_word   = {r_hdr[159:80], r_hdr[63:0]};
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_csum  = r_out_csum;
    assign out_match = r_out_match;
    assign w_hs      = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= c_PTR_RST;
            r_hdr       <= '0;
            r_lat_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_csum  <= '0;
            r_out_match <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_hdr     <= w_sel_hdr;
                        r_rr_ptr  <= w_gnt_id;
                        r_lat_cnt <= '0;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_lat_cnt <= r_lat_cnt + 3'd1;
                    if (r_lat_cnt == c_LAT) begin
                        r_out_csum  <= cs_result;
                        r_out_match <= (cs_result == r_hdr[79:64]);
                        r_out_id    <= r_rr_ptr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef NX_IPCSUM_SCHED_STATS_EN
    logic [31:0] r_stat_done;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_stat_done <= '0;
            r_stat_mis  <= '0;
        end else if (w_hs) begin
            if (r_stat_done != 32'hFFFF_FFFF) begin
                r_stat_done <= r_stat_done + 32'd1;
            end
            if (!r_out_match && (r_stat_mis != 32'hFFFF_FFFF)) begin
                r_stat_mis <= r_stat_mis + 32'd1;
            end
        end
    end

    assign stat_done_cnt     = r_stat_done;
    assign stat_mismatch_cnt = r_stat_mis;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nx_ipchecksum_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_nx_ipchecksum_sched
// Purpose  : Self-checking bench for nx_ipchecksum_sched. Includes a
//            behavioural checksum unit that only returns the correct sum once
//            the words have been stable for the configured latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nx_ipchecksum_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NREQ-1:0]     req_valid,  req_ready;
    logic [NREQ*160-1:0] req_hdr;
    logic [143:0]        cs_word;
    logic [15:0]         cs_result;
    logic                out_valid, out_ready, out_match;
    logic [IDW-1:0]      out_id;
    logic [15:0]         out_csum;

    logic [NREQ-1:0]     req_valid3, req_ready3;
    logic [NREQ*160-1:0] req_hdr3;
    logic [143:0]        cs_word3;
    logic [15:0]         cs_result3;
    logic                out_valid3, out_ready3, out_match3;
    logic [IDW-1:0]      out_id3;
    logic [15:0]         out_csum3;

`ifdef NX_IPCSUM_SCHED_STATS_EN
    logic        stat_clr, stat_clr3;
    logic [31:0] stat_done_cnt, stat_mismatch_cnt, stat_done_cnt3, stat_mismatch_cnt3;
`endif

    nx_ipchecksum_sched #(.NUM_REQ(NREQ), .ID_W(IDW), .CS_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_hdr(req_hdr),
        .req_ready(req_ready), .cs_word(cs_word), .cs_result(cs_result),
`ifdef NX_IPCSUM_SCHED_STATS_EN
        .stat_clr(stat_clr), .stat_done_cnt(stat_done_cnt),
        .stat_mismatch_cnt(stat_mismatch_cnt),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_csum(out_csum), .out_match(out_match)
    );

    nx_ipchecksum_sched #(.NUM_REQ(NREQ), .ID_W(IDW), .CS_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_hdr(req_hdr3),
        .req_ready(req_ready3), .cs_word(cs_word3), .cs_result(cs_result3),
`ifdef NX_IPCSUM_SCHED_STATS_EN
        .stat_clr(stat_clr3), .stat_done_cnt(stat_done_cnt3),
        .stat_mismatch_cnt(stat_mismatch_cnt3),
`endif
        .out_valid(out_valid3), .out_ready(out_ready3), .out_id(out_id3),
        .out_csum(out_csum3), .out_match(out_match3)
    );

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference arithmetic ----------------
    function automatic logic [15:0] hword(input logic [159:0] h, input int w);
        return h[159-16*w -: 16];
    endfunction

    function automatic logic [143:0] words_of(input logic [159:0] h);
        logic [143:0] r;
        int j;
        r = '0;
        j = 0;
        for (int w = 0; w < 10; w++) begin
            if (w != 5) begin
                r[143-16*j -: 16] = hword(h, w);
                j++;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] csum9(input logic [143:0] ws);
        logic [31:0] s;
        s = 32'd0;
        for (int j = 0; j < 9; j++) s = s + 32'(ws[143-16*j -: 16]);
        repeat (3) s = (s & 32'h0000_FFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic logic [15:0] csum_hdr(input logic [159:0] h);
        return csum9(words_of(h));
    endfunction

    function automatic logic [159:0] rand_hdr(input bit force_match);
        logic [159:0] h;
        for (int w = 0; w < 5; w++) h[159-32*w -: 32] = $urandom;
        if (force_match) h[79:64] = csum_hdr(h);
        return h;
    endfunction

    // ---------------- behavioural checksum units ----------------
    // Result is only correct once cs_word has been stable for LAT cycles;
    // earlier it is deliberately wrong.
    logic [143:0] m_last1, m_last3;
    int           m_age1 = 0, m_age3 = 0;

    always @(posedge clk) begin
        if (cs_word == m_last1) begin
            if (m_age1 < 100) m_age1 <= m_age1 + 1;
        end else begin
            m_last1 <= cs_word;
            m_age1  <= 0;
        end
        if (cs_word3 == m_last3) begin
            if (m_age3 < 100) m_age3 <= m_age3 + 1;
        end else begin
            m_last3 <= cs_word3;
            m_age3  <= 0;
        end
    end

    always_comb begin
        int a1;
        int a3;
        a1 = (cs_word == m_last1) ? m_age1 + 1 : 0;
        a3 = (cs_word3 == m_last3) ? m_age3 + 1 : 0;
        cs_result  = (a1 >= 1) ? csum9(cs_word)  : ~csum9(cs_word);
        cs_result3 = (a3 >= 3) ? csum9(cs_word3) : ~csum9(cs_word3);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_valid3 = '0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic run_single(input int idx, input logic [159:0] hdr,
                              input logic [15:0] ecs, input logic em);
        step();
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_hdr[160*idx +: 160] = hdr;
        out_ready = 1'b1;
        #1;
        chk("grant", req_ready, 160'(4'b0001 << idx));
        step();
        req_valid = '0;
        #1;
        chk("ready_in_calc", req_ready, 0);
        chk("cs_word", cs_word, words_of(hdr));
        chk("ov_early_1", out_valid, 0);
        step();
        #1;
        chk("ov_early_2", out_valid, 0);
        step();
        #1;
        chk("ov_at_T3", out_valid, 1);
        chk("out_id", out_id, idx);
        chk("out_csum", out_csum, ecs);
        chk("out_match", out_match, em);
        step();
        #1;
        chk("ov_after_hs", out_valid, 0);
    endtask

    // ---------------- randomized engine with reference model ----------------
    logic         pend [NREQ];
    logic [159:0] phdr [NREQ];
    int           last_g;
    bit           inflight;
    int           g_cyc, cyc;
    logic [159:0] exp_hdr;
    int           exp_gid;
    int           grants[$];

    task automatic model_init();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        last_g   = NREQ - 1;
        inflight = 1'b0;
        cyc      = 0;
        g_cyc    = 0;
        grants.delete();
    endtask

    task automatic run_engine(input int ncyc, input int mode);
        for (int c = 0; c < ncyc; c++) begin
            logic [NREQ-1:0] exp_rdy;
            bit              exp_ov;
            int              g;
            step();
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && (mode == 1 || $urandom_range(0, 3) == 0)) begin
                    pend[i] = 1'b1;
                    phdr[i] = rand_hdr($urandom_range(0, 1) == 1);
                end
                req_valid[i] = pend[i];
                req_hdr[160*i +: 160] = phdr[i];
            end
            out_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            // next requester after the last winner, cyclically
            exp_rdy = '0;
            g = -1;
            if (!inflight) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && pend[(last_g + k) % NREQ]) g = (last_g + k) % NREQ;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            exp_ov = inflight && (cyc >= g_cyc + 3);
            chk("rnd_req_ready", req_ready, exp_rdy);
            chk("rnd_out_valid", out_valid, exp_ov);
            if (exp_ov && out_valid) begin
                chk("rnd_out_id", out_id, exp_gid);
                chk("rnd_out_csum", out_csum, csum_hdr(exp_hdr));
                chk("rnd_out_match", out_match, csum_hdr(exp_hdr) == hword(exp_hdr, 5));
            end
            if (g >= 0) begin
                pend[g]  = 1'b0;
                inflight = 1'b1;
                g_cyc    = cyc;
                exp_hdr  = phdr[g];
                exp_gid  = g;
                last_g   = g;
                grants.push_back(g);
            end else if (exp_ov && out_ready) begin
                inflight = 1'b0;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int           idx;
        logic [159:0] hdr;
        logic [15:0]  csum;
        logic         match;
    } vec_t;

    vec_t vt [4];

    localparam logic [159:0] c_HDR_OK  = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;
    localparam logic [159:0] c_HDR_BAD = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;

    initial begin
        logic [159:0] h;
        logic [15:0]  held_cs;
        int           exp_order [5];

        rst = 1'b1;
        req_valid = '0;  req_hdr = '0;  out_ready = 1'b0;
        req_valid3 = '0; req_hdr3 = '0; out_ready3 = 1'b0;
`ifdef NX_IPCSUM_SCHED_STATS_EN
        stat_clr = 1'b0; stat_clr3 = 1'b0;
`endif
        vt[0] = '{0, c_HDR_OK,  16'hb861, 1'b1};
        vt[1] = '{0, c_HDR_BAD, 16'hb861, 1'b0};
        h = rand_hdr(1'b1);
        vt[2] = '{3, h, csum_hdr(h), 1'b1};
        h = rand_hdr(1'b0);
        h[79:64] = ~csum_hdr(h);
        vt[3] = '{2, h, csum_hdr(h), 1'b0};

        // reset state
        do_reset();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_csum", out_csum, 0);
        chk("rst_out_match", out_match, 0);
        chk("rst_cs_word", cs_word, 0);

        // table-driven single operations
        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_single(vt[i].idx, vt[i].hdr, vt[i].csum, vt[i].match);
`ifdef NX_IPCSUM_SCHED_STATS_EN
            chk("stat_done", stat_done_cnt, 1);
            chk("stat_mismatch", stat_mismatch_cnt, vt[i].match ? 0 : 1);
`endif
        end
`ifdef NX_IPCSUM_SCHED_STATS_EN
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("stat_clr_done", stat_done_cnt, 0);
        chk("stat_clr_mismatch", stat_mismatch_cnt, 0);
`endif

        // all requesters continuously valid: strict rotation from 0
        do_reset();
        model_init();
        run_engine(24, 1);
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            chk("rr_order", (grants.size() > k) ? grants[k] : -1, exp_order[k]);
        end

        // randomized traffic
        do_reset();
        model_init();
        run_engine(400, 0);

        // back-pressure in DONE: outputs hold, no grants
        do_reset();
        step();
        req_valid = 4'b0010;
        req_hdr[160*1 +: 160] = c_HDR_OK;
        out_ready = 1'b0;
        #1;
        chk("bp_grant", req_ready, 4'b0010);
        step();
        req_valid = 4'b0100;
        req_hdr[160*2 +: 160] = c_HDR_BAD;
        #1;
        chk("bp_calc_ready", req_ready, 0);
        step();
        step();
        held_cs = csum_hdr(c_HDR_OK);
        for (int k = 0; k < 10; k++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_id", out_id, 1);
            chk("bp_out_csum", out_csum, held_cs);
            chk("bp_out_match", out_match, 1);
            chk("bp_req_ready", req_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_hs_valid", out_valid, 1);
        chk("bp_hs_ready", req_ready, 0);
        step();
        #1;
        chk("bp_after_hs_valid", out_valid, 0);
        chk("bp_next_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (4) step();

        // reset during CALC abandons the op
        do_reset();
        step();
        req_valid = 4'b0010;
        req_hdr[160*1 +: 160] = c_HDR_OK;
        out_ready = 1'b1;
        #1;
        chk("rc_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rc_out_valid", out_valid, 0);
        chk("rc_out_id", out_id, 0);
        chk("rc_out_csum", out_csum, 0);
        chk("rc_out_match", out_match, 0);
        chk("rc_cs_word", cs_word, 0);
        chk("rc_req_ready", req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            chk("rc_no_result", out_valid, 0);
        end
        run_single(2, c_HDR_BAD, 16'hb861, 1'b0);

        // CS_LATENCY=3 instance: result at T+5, sampled after 3 stable cycles
        do_reset();
        step();
        req_valid3 = 4'b0001;
        req_hdr3[159:0] = c_HDR_OK;
        out_ready3 = 1'b1;
        #1;
        chk("l3_grant", req_ready3, 4'b0001);
        for (int k = 1; k <= 6; k++) begin
            step();
            req_valid3 = '0;
            #1;
            chk("l3_out_valid", out_valid3, k == 5);
            if (k == 5) begin
                chk("l3_out_csum", out_csum3, 16'hb861);
                chk("l3_out_match", out_match3, 1);
                chk("l3_out_id", out_id3, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
